// File: rtl/galvo_scan_ctrl.sv
// galvo_scan_ctrl: raster scan sequencer for the galvo mirrors (clk_adc domain).
// Each galvo_go advances one pixel: the new position goes to the SPI driver,
// the block waits for spi_done (or a timeout), commits the code to galvoh/galvov,
// and inserts a flyback settle after every line change.
// Build option: define GALVO_SERPENTINE_EN for bidirectional scanning (odd lines
// run right-to-left and a line change moves V only). Undefined gives a
// unidirectional raster with an H write back to h_start after every V step.
module galvo_scan_ctrl #(
   parameter int H_PIXELS       = 1024,
   parameter int V_LINES        = 1024,
   parameter int FLYBACK_CYCLES = 256,
   parameter int SPI_TIMEOUT    = 1023
) (
   input  logic        clk_adc,
   input  logic        rst_adc_n,
   input  logic        enable,
   input  logic        galvo_go,
   input  logic [10:0] h_start,
   input  logic [10:0] v_start,
   input  logic        err_clr,
   input  logic        spi_done,
   output logic        spi_start,
   output logic        spi_axis,
   output logic [10:0] spi_data,
   output logic [10:0] galvoh,
   output logic [10:0] galvov,
   output logic        pixel_valid,
   output logic        line_end,
   output logic        frame_end,
   output logic        busy,
   output logic        overrun,
   output logic        spi_timeout
);

   localparam logic [10:0] H_LAST   = 11'(H_PIXELS - 1);
   localparam logic [10:0] V_LAST   = 11'(V_LINES - 1);
   localparam logic [15:0] FLY_LAST = 16'(FLYBACK_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(SPI_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_H,
      S_WAIT_H,
      S_LOAD_V,
      S_WAIT_V,
      S_FLYBACK,
      S_PIXEL
   } state_t;

   state_t      state_q;
   logic [10:0] h_idx_q;
   logic [10:0] v_idx_q;
   logic [10:0] h_base_q;
   logic [10:0] v_base_q;
   logic        need_h_q;      // a V write is followed by an H write to h_base
   logic        need_fly_q;    // the current transfer chain ends in FLYBACK
   logic [15:0] wait_cnt_q;
   logic [15:0] fly_cnt_q;
   logic        spi_start_q;
   logic        spi_axis_q;
   logic [10:0] spi_data_q;
   logic [10:0] galvoh_q;
   logic [10:0] galvov_q;
   logic        line_end_q;
   logic        frame_end_q;
   logic        overrun_q;
   logic        spi_timeout_q;

   logic [10:0] h_idx_inc;
   logic [10:0] v_idx_inc;
   logic [10:0] h_step_code;
   logic        line_h_write;
   logic        xfer_end;

   // Next pixel code and line-change behaviour for the selected scan pattern
   always_comb begin
      h_idx_inc = h_idx_q + 11'd1;
      v_idx_inc = v_idx_q + 11'd1;
`ifdef GALVO_SERPENTINE_EN
      // Odd lines mirror the index so the beam walks back right-to-left;
      // the first code of an odd line equals the last code of the previous one.
      if (v_idx_q[0]) begin
         h_step_code = h_base_q + H_LAST - h_idx_inc;
      end else begin
         h_step_code = h_base_q + h_idx_inc;
      end
      line_h_write = 1'b0;
`else
      h_step_code  = h_base_q + h_idx_inc;
      line_h_write = 1'b1;
`endif
      // Timeout counts as completion; the code is committed either way.
      xfer_end = spi_done || (wait_cnt_q == TO_LAST);
   end

   // Scan sequencer: state, indices, SPI request, committed positions, flags
   always_ff @(posedge clk_adc) begin
      if (!rst_adc_n) begin
         state_q       <= S_IDLE;
         h_idx_q       <= '0;
         v_idx_q       <= '0;
         h_base_q      <= '0;
         v_base_q      <= '0;
         need_h_q      <= 1'b0;
         need_fly_q    <= 1'b0;
         wait_cnt_q    <= '0;
         fly_cnt_q     <= '0;
         spi_start_q   <= 1'b0;
         spi_axis_q    <= 1'b0;
         spi_data_q    <= '0;
         galvoh_q      <= '0;
         galvov_q      <= '0;
         line_end_q    <= 1'b0;
         frame_end_q   <= 1'b0;
         overrun_q     <= 1'b0;
         spi_timeout_q <= 1'b0;
      end else begin
         spi_start_q <= 1'b0;
         line_end_q  <= 1'b0;
         frame_end_q <= 1'b0;

         // Clear first so a set in the same cycle wins.
         if (err_clr) begin
            overrun_q     <= 1'b0;
            spi_timeout_q <= 1'b0;
         end
         if (galvo_go && (state_q != S_PIXEL)) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  h_base_q    <= h_start;
                  v_base_q    <= v_start;
                  h_idx_q     <= '0;
                  v_idx_q     <= '0;
                  need_h_q    <= 1'b1;
                  need_fly_q  <= 1'b0;
                  spi_start_q <= 1'b1;
                  spi_axis_q  <= 1'b1;
                  spi_data_q  <= v_start;
                  state_q     <= S_LOAD_V;
               end
            end

            S_LOAD_H: begin
               wait_cnt_q <= '0;
               state_q    <= S_WAIT_H;
            end

            S_LOAD_V: begin
               wait_cnt_q <= '0;
               state_q    <= S_WAIT_V;
            end

            S_WAIT_H: begin
               if (xfer_end) begin
                  galvoh_q <= spi_data_q;
                  if (!spi_done) begin
                     spi_timeout_q <= 1'b1;
                  end
                  if (!enable) begin
                     state_q <= S_IDLE;
                  end else if (need_fly_q) begin
                     fly_cnt_q <= '0;
                     state_q   <= S_FLYBACK;
                  end else begin
                     state_q <= S_PIXEL;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
            end

            S_WAIT_V: begin
               if (xfer_end) begin
                  galvov_q <= spi_data_q;
                  if (!spi_done) begin
                     spi_timeout_q <= 1'b1;
                  end
                  if (!enable) begin
                     state_q <= S_IDLE;
                  end else if (need_h_q) begin
                     // Chained H write always targets the line start code.
                     spi_start_q <= 1'b1;
                     spi_axis_q  <= 1'b0;
                     spi_data_q  <= h_base_q;
                     state_q     <= S_LOAD_H;
                  end else if (need_fly_q) begin
                     fly_cnt_q <= '0;
                     state_q   <= S_FLYBACK;
                  end else begin
                     state_q <= S_PIXEL;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
            end

            S_FLYBACK: begin
               if (!enable) begin
                  state_q <= S_IDLE;
               end else if (fly_cnt_q == FLY_LAST) begin
                  state_q <= S_PIXEL;
               end else begin
                  fly_cnt_q <= fly_cnt_q + 16'd1;
               end
            end

            S_PIXEL: begin
               if (!enable) begin
                  state_q <= S_IDLE;
               end else if (galvo_go) begin
                  spi_start_q <= 1'b1;
                  if (h_idx_q != H_LAST) begin
                     h_idx_q    <= h_idx_inc;
                     spi_axis_q <= 1'b0;
                     spi_data_q <= h_step_code;
                     need_h_q   <= 1'b0;
                     need_fly_q <= 1'b0;
                     state_q    <= S_LOAD_H;
                  end else begin
                     line_end_q <= 1'b1;
                     spi_axis_q <= 1'b1;
                     need_fly_q <= 1'b1;
                     h_idx_q    <= '0;
                     state_q    <= S_LOAD_V;
                     if (v_idx_q != V_LAST) begin
                        v_idx_q    <= v_idx_inc;
                        spi_data_q <= v_base_q + v_idx_inc;
                        need_h_q   <= line_h_write;
                     end else begin
                        // Frame wrap: restart from freshly sampled start codes.
                        frame_end_q <= 1'b1;
                        h_base_q    <= h_start;
                        v_base_q    <= v_start;
                        v_idx_q     <= '0;
                        spi_data_q  <= v_start;
                        need_h_q    <= 1'b1;
                     end
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign spi_start   = spi_start_q;
   assign spi_axis    = spi_axis_q;
   assign spi_data    = spi_data_q;
   assign galvoh      = galvoh_q;
   assign galvov      = galvov_q;
   assign pixel_valid = (state_q == S_PIXEL);
   assign line_end    = line_end_q;
   assign frame_end   = frame_end_q;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign spi_timeout = spi_timeout_q;

endmodule

// File: tb/tb_galvo_scan_ctrl.sv
// Testbench for galvo_scan_ctrl: 4x2 scan, 8-cycle flyback, SPI timeout 16,
// SPI responder answering spi_done 5 cycles after each spi_start.
// Also valid with GALVO_SERPENTINE_EN defined (serpentine expectation table).
module tb_galvo_scan_ctrl;

   localparam int H_PIXELS       = 4;
   localparam int V_LINES        = 2;
   localparam int FLYBACK_CYCLES = 8;
   localparam int SPI_TIMEOUT    = 16;

   logic        clk_adc;
   logic        rst_adc_n;
   logic        enable;
   logic        galvo_go;
   logic [10:0] h_start;
   logic [10:0] v_start;
   logic        err_clr;
   logic        spi_done;
   logic        spi_start;
   logic        spi_axis;
   logic [10:0] spi_data;
   logic [10:0] galvoh;
   logic [10:0] galvov;
   logic        pixel_valid;
   logic        line_end;
   logic        frame_end;
   logic        busy;
   logic        overrun;
   logic        spi_timeout;

   galvo_scan_ctrl #(
      .H_PIXELS      (H_PIXELS),
      .V_LINES       (V_LINES),
      .FLYBACK_CYCLES(FLYBACK_CYCLES),
      .SPI_TIMEOUT   (SPI_TIMEOUT)
   ) dut (
      .clk_adc    (clk_adc),
      .rst_adc_n  (rst_adc_n),
      .enable     (enable),
      .galvo_go   (galvo_go),
      .h_start    (h_start),
      .v_start    (v_start),
      .err_clr    (err_clr),
      .spi_done   (spi_done),
      .spi_start  (spi_start),
      .spi_axis   (spi_axis),
      .spi_data   (spi_data),
      .galvoh     (galvoh),
      .galvov     (galvov),
      .pixel_valid(pixel_valid),
      .line_end   (line_end),
      .frame_end  (frame_end),
      .busy       (busy),
      .overrun    (overrun),
      .spi_timeout(spi_timeout)
   );

   initial clk_adc = 1'b0;
   always #5 clk_adc = ~clk_adc;

   // Cycle number; at a negedge it names the cycle that began at the last posedge.
   int cyc = 0;
   always @(posedge clk_adc) cyc <= cyc + 1;

   // SPI responder: logs {axis, data} of each request, answers 5 cycles later.
   logic [11:0] wlog[$];
   bit          spi_mute = 1'b0;
   int          done_cyc = 0;
   int          spi_cnt  = -1;

   initial begin
      spi_done = 1'b0;
      forever begin
         @(negedge clk_adc);
         spi_done = 1'b0;
         if (spi_cnt > 0) begin
            spi_cnt = spi_cnt - 1;
            if (spi_cnt == 0) begin
               spi_done = 1'b1;
               done_cyc = cyc;
               spi_cnt  = -1;
            end
         end
         if (spi_start === 1'b1) begin
            wlog.push_back({spi_axis, spi_data});
            if (!spi_mute) spi_cnt = 5;
         end
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Wait (bounded) for pixel_valid; returns the cycle it was seen high.
   task automatic wait_pv(input string name, output int p);
      p = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_adc);
         if (pixel_valid === 1'b1) begin
            p = cyc;
            break;
         end
      end
      if (p < 0) begin
         n_chk++;
         n_bad++;
         $display("FAIL %s pixel_valid wait: got 0 after 200 cycles, expected 1", name);
      end
   endtask

   task automatic pulse_go();
      @(negedge clk_adc);
      galvo_go = 1'b1;
      @(negedge clk_adc);
      galvo_go = 1'b0;
   endtask

   function automatic logic [31:0] log_at(input int i);
      if (wlog.size() > i) return 32'(wlog[i]);
      return 32'hFFFF_FFFF;
   endfunction

   // One go pulse: expected writes ({axis,code}), committed codes, pulses,
   // and cycles from the last spi_done to pixel_valid (1, or 1+flyback).
   typedef struct {
      int le;
      int fe;
      int nw;
      int w0;
      int w1;
      int h;
      int v;
      int dly;
   } vec_t;

   localparam int HW = 0;
   localparam int VW = 2048;

   vec_t tbl[8];
   int   p;
   int   s;
   int   t;

   initial begin
      tbl[0] = '{0, 0, 1, HW + 101, 0, 101, 200, 1};
      tbl[1] = '{0, 0, 1, HW + 102, 0, 102, 200, 1};
      tbl[2] = '{0, 0, 1, HW + 103, 0, 103, 200, 1};
`ifdef GALVO_SERPENTINE_EN
      tbl[3] = '{1, 0, 1, VW + 201, 0, 103, 201, 9};
      tbl[4] = '{0, 0, 1, HW + 102, 0, 102, 201, 1};
      tbl[5] = '{0, 0, 1, HW + 101, 0, 101, 201, 1};
      tbl[6] = '{0, 0, 1, HW + 100, 0, 100, 201, 1};
`else
      tbl[3] = '{1, 0, 2, VW + 201, HW + 100, 100, 201, 9};
      tbl[4] = '{0, 0, 1, HW + 101, 0, 101, 201, 1};
      tbl[5] = '{0, 0, 1, HW + 102, 0, 102, 201, 1};
      tbl[6] = '{0, 0, 1, HW + 103, 0, 103, 201, 1};
`endif
      tbl[7] = '{1, 1, 2, VW + 200, HW + 100, 100, 200, 9};

      rst_adc_n = 1'b0;
      enable    = 1'b0;
      galvo_go  = 1'b0;
      err_clr   = 1'b0;
      h_start   = 11'd100;
      v_start   = 11'd200;

      // Reset state
      repeat (3) @(negedge clk_adc);
      chk("rst spi_start", 32'(spi_start), 0);
      chk("rst spi_data", 32'(spi_data), 0);
      chk("rst galvoh", 32'(galvoh), 0);
      chk("rst galvov", 32'(galvov), 0);
      chk("rst pixel_valid", 32'(pixel_valid), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst line_end", 32'(line_end), 0);
      chk("rst frame_end", 32'(frame_end), 0);
      chk("rst overrun", 32'(overrun), 0);
      chk("rst spi_timeout", 32'(spi_timeout), 0);
      rst_adc_n = 1'b1;
      @(negedge clk_adc);
      chk("idle busy", 32'(busy), 0);

      // Start: V write 200 then H write 100, no flyback
      wlog.delete();
      enable = 1'b1;
      @(negedge clk_adc);
      chk("start spi_start", 32'(spi_start), 1);
      chk("start spi_axis", 32'(spi_axis), 1);
      chk("start busy", 32'(busy), 1);
      wait_pv("start", p);
      chk("start nwrites", 32'(wlog.size()), 2);
      chk("start w0", log_at(0), VW + 200);
      chk("start w1", log_at(1), HW + 100);
      chk("start galvoh", 32'(galvoh), 100);
      chk("start galvov", 32'(galvov), 200);
      chk("start settle", 32'(p - done_cyc), 1);
      $display("start: galvoh=%0d galvov=%0d", galvoh, galvov);

      // One full frame of go pulses
      for (int i = 0; i < 8; i++) begin
         wlog.delete();
         pulse_go();
         chk($sformatf("v%0d spi_start", i), 32'(spi_start), 1);
         chk($sformatf("v%0d pixel_valid", i), 32'(pixel_valid), 0);
         chk($sformatf("v%0d line_end", i), 32'(line_end), tbl[i].le);
         chk($sformatf("v%0d frame_end", i), 32'(frame_end), tbl[i].fe);
         wait_pv($sformatf("v%0d", i), p);
         chk($sformatf("v%0d nwrites", i), 32'(wlog.size()), tbl[i].nw);
         chk($sformatf("v%0d w0", i), log_at(0), tbl[i].w0);
         if (tbl[i].nw == 2) chk($sformatf("v%0d w1", i), log_at(1), tbl[i].w1);
         chk($sformatf("v%0d galvoh", i), 32'(galvoh), tbl[i].h);
         chk($sformatf("v%0d galvov", i), 32'(galvov), tbl[i].v);
         chk($sformatf("v%0d settle", i), 32'(p - done_cyc), tbl[i].dly);
         $display("vec %0d: galvoh=%0d galvov=%0d writes=%0d settle=%0d",
                  i, galvoh, galvov, wlog.size(), p - done_cyc);
      end
      chk("frame overrun", 32'(overrun), 0);

      // Overrun: a go during WAIT_H is dropped
      wlog.delete();
      pulse_go();
      @(negedge clk_adc);
      galvo_go = 1'b1;
      @(negedge clk_adc);
      galvo_go = 1'b0;
      chk("ovr overrun", 32'(overrun), 1);
      wait_pv("ovr", p);
      chk("ovr galvoh", 32'(galvoh), 101);
      chk("ovr nwrites", 32'(wlog.size()), 1);
      $display("overrun: overrun=%0d galvoh=%0d", overrun, galvoh);

      // Timeout: silent SPI, 16 wait cycles after the LOAD cycle
      spi_mute = 1'b1;
      wlog.delete();
      pulse_go();
      s = cyc;
      t = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_adc);
         if (spi_timeout === 1'b1) begin
            t = cyc;
            break;
         end
      end
      chk("to delay", 32'(t - s), 17);
      wait_pv("to", p);
      spi_mute = 1'b0;
      chk("to galvoh", 32'(galvoh), 102);
      chk("to sticky", 32'(spi_timeout), 1);
      chk("to overrun sticky", 32'(overrun), 1);
      $display("timeout: delay=%0d galvoh=%0d", t - s, galvoh);
      @(negedge clk_adc);
      err_clr = 1'b1;
      @(negedge clk_adc);
      err_clr = 1'b0;
      chk("clr overrun", 32'(overrun), 0);
      chk("clr spi_timeout", 32'(spi_timeout), 0);

      // Disable during WAIT_V: transfer completes, then IDLE with positions held
      pulse_go();
      wait_pv("pre-dis", p);
      chk("pre-dis galvoh", 32'(galvoh), 103);
      wlog.delete();
      pulse_go();
      chk("dis line_end", 32'(line_end), 1);
      @(negedge clk_adc);
      enable = 1'b0;
      t = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_adc);
         if (busy === 1'b0) begin
            t = cyc;
            break;
         end
      end
      chk("dis idle delay", 32'(t - done_cyc), 1);
      chk("dis nwrites", 32'(wlog.size()), 1);
      chk("dis w0", log_at(0), VW + 201);
      chk("dis galvov", 32'(galvov), 201);
      chk("dis galvoh", 32'(galvoh), 103);
      repeat (5) @(negedge clk_adc);
      chk("dis busy held", 32'(busy), 0);
      chk("dis pixel_valid", 32'(pixel_valid), 0);
      $display("disable: busy=%0d galvoh=%0d galvov=%0d", busy, galvoh, galvov);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
